ip_encode: RTL
==============

# ip_encode

Byte-serial IPv4 header generator for the transmit path, the counterpart of the receive-side IPv4 header decoder. On a start request it latches source/destination addresses and UDP payload length, computes the one's-complement header checksum over a fixed 20-byte header (no options), then streams the header MSB-first over a valid/ready byte interface. It sits between the UDP transmit builder and the MAC transmit framer.

## Interface

- TTL, 8'd64, time-to-live field value
- PROTOCOL, 8'd17, protocol field value (UDP)
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- start  input  1  request a header; sampled only in IDLE
- payload_len  input  16  IP payload length in bytes (UDP header + data)
- sa  input  32  source address, latched on accepted start
- da  input  32  destination address, latched on accepted start
- ready  input  1  downstream accepts dout this cycle
- dout  output  8  header byte
- valid  output  1  dout is valid
- busy  output  1  high in CALC and SEND
- done  output  1  one-cycle pulse after last header byte accepted
- err  output  1  one-cycle pulse when start is rejected for length overflow

## Operation

- Header words, in order: 0x4500; total_len = payload_len + 20; ident; 0x4000 (DF set, offset 0); {TTL, PROTOCOL}; checksum; sa[31:16]; sa[15:0]; da[31:16]; da[15:0].
- ident: 16-bit register, reset 0, increments by 1 (wraps 0xFFFF→0x0000) on every done pulse; value used is the one held at start acceptance.
- States: IDLE, CALC, SEND.
- IDLE: start=1 and payload_len ≤ 0xFFEB → latch sa, da, total_len, ident; clear sum; go CALC. start=1 and payload_len > 0xFFEB → err pulse next cycle, stay IDLE, nothing latched, ident unchanged.
- CALC: 10 cycles, word index 0..9; each cycle sum ← sum + word with end-around carry (17-bit add, carry added back, result 16 bits). Word 5 (checksum) contributes 0. After index 9, checksum ← ~sum; go SEND.
- SEND: byte index 0..19, big-endian per word (high byte first). valid=1; byte index advances only when valid & ready. On acceptance of byte 19: valid drops next cycle, done pulses, ident increments, go IDLE.
- start while busy is ignored (no queuing); sa/da/payload_len changes after acceptance have no effect.
- Reset values: dout=0, valid=0, busy=0, done=0, err=0, ident=0, state IDLE. Reset asserted mid-CALC or mid-SEND aborts immediately; no done, no ident increment.

## Timing

- Start accepted at edge N → busy=1 from N; CALC occupies edges N+1..N+10; valid=1 with byte 0 after edge N+10 (valid first seen in cycle 11 after start).
- With ready held high: 20 consecutive bytes, done high in the cycle after byte 19 is accepted; busy drops in that same cycle; new start may be accepted in that cycle.
- ready low: dout and valid hold stable, no index advance; arbitrarily long stalls legal.
- dout, valid, done, err, busy are registered outputs.
- Minimum header-to-header period: 1 (accept) + 10 (CALC) + 20 (SEND) = 31 cycles.

## Test plan

- Reset, start with sa=0xC0A80001, da=0xC0A800C7, payload_len=0x005F, ready=1 → bytes 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7, then done pulse.
- Repeat immediately with same inputs → ident=0x0001, bytes 4–5 = 00 01, checksum bytes = B8 60.
- Randomly toggle ready during SEND → identical 20-byte sequence; dout stable whenever valid & !ready; exactly one done.
- payload_len=0xFFEB → total_len bytes FF FF, header sent; payload_len=0xFFEC → err pulse, valid never rises, busy stays 0, ident unchanged.
- start pulsed during CALC and SEND with different sa → ignored; output matches first request.
- Deassert rst_n at byte 7 of SEND → valid/busy low immediately, ident=0; next start produces a correct header with ident 0x0000.

Source files
------------

// File: rtl/ip_encode.sv
// ip_encode: byte-serial IPv4 header generator (20-byte header, no options).
// Latches addresses and length on start, folds the ten header words into a
// one's-complement checksum over ten cycles, then streams the header
// MSB-first over a valid/ready byte interface.
module ip_encode #(
    parameter logic [7:0] TTL      = 8'd64,
    parameter logic [7:0] PROTOCOL = 8'd17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] payload_len,
    input  logic [31:0] sa,
    input  logic [31:0] da,
    input  logic        ready,
    output logic [7:0]  dout,
    output logic        valid,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_t;

    // Largest payload that keeps total_len within 16 bits (0xFFFF - 20).
    localparam logic [15:0] MAX_PAYLOAD = 16'hFFEB;

    state_t      state_r, state_s;
    logic [15:0] sum_r, sum_s;
    logic [15:0] csum_r, csum_s;
    logic [4:0]  idx_r, idx_s;
    logic [31:0] sa_r, sa_s;
    logic [31:0] da_r, da_s;
    logic [15:0] tl_r, tl_s;
    logic [15:0] ident_r, ident_s;
    logic [7:0]  dout_r, dout_s;
    logic        valid_r, valid_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        err_r, err_s;
    logic [15:0] sum_add_s;

    // One's-complement add: 17-bit sum with the carry folded back in.
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    // Header word by index; the checksum slot is supplied by the caller.
    function automatic logic [15:0] hdr_word(input logic [3:0] widx, input logic [15:0] tl,
                                             input logic [15:0] id, input logic [15:0] cks,
                                             input logic [31:0] s_addr, input logic [31:0] d_addr);
        logic [15:0] w;
        case (widx)
            4'd0:    w = 16'h4500;
            4'd1:    w = tl;
            4'd2:    w = id;
            4'd3:    w = 16'h4000;
            4'd4:    w = {TTL, PROTOCOL};
            4'd5:    w = cks;
            4'd6:    w = s_addr[31:16];
            4'd7:    w = s_addr[15:0];
            4'd8:    w = d_addr[31:16];
            4'd9:    w = d_addr[15:0];
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // Header byte by index, high byte of each word first.
    function automatic logic [7:0] hdr_byte(input logic [4:0] bidx, input logic [15:0] tl,
                                            input logic [15:0] id, input logic [15:0] cks,
                                            input logic [31:0] s_addr, input logic [31:0] d_addr);
        logic [15:0] w;
        w = hdr_word(bidx[4:1], tl, id, cks, s_addr, d_addr);
        return bidx[0] ? w[7:0] : w[15:8];
    endfunction

    // Next-state and next-output logic for the IDLE/CALC/SEND sequencer.
    always_comb begin
        state_s   = state_r;
        sum_s     = sum_r;
        csum_s    = csum_r;
        idx_s     = idx_r;
        sa_s      = sa_r;
        da_s      = da_r;
        tl_s      = tl_r;
        ident_s   = ident_r;
        dout_s    = dout_r;
        valid_s   = valid_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        err_s     = 1'b0;
        // Checksum slot contributes zero while summing.
        sum_add_s = ones_add(sum_r, hdr_word(idx_r[3:0], tl_r, ident_r, 16'h0000, sa_r, da_r));
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (payload_len <= MAX_PAYLOAD) begin
                        sa_s    = sa;
                        da_s    = da;
                        tl_s    = payload_len + 16'd20;
                        sum_s   = 16'h0000;
                        idx_s   = 5'd0;
                        busy_s  = 1'b1;
                        state_s = CALC;
                    end else begin
                        err_s   = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                sum_s = sum_add_s;
                if (idx_r == 5'd9) begin
                    csum_s  = ~sum_add_s;
                    idx_s   = 5'd0;
                    valid_s = 1'b1;
                    dout_s  = hdr_byte(5'd0, tl_r, ident_r, ~sum_add_s, sa_r, da_r);
                    state_s = SEND;
                end else begin
                    idx_s   = idx_r + 5'd1;
                end
            end
            SEND: begin
                if (ready) begin
                    if (idx_r == 5'd19) begin
                        valid_s = 1'b0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        dout_s  = 8'h00;
                        idx_s   = 5'd0;
                        ident_s = ident_r + 16'd1;
                        state_s = IDLE;
                    end else begin
                        idx_s   = idx_r + 5'd1;
                        dout_s  = hdr_byte(idx_r + 5'd1, tl_r, ident_r, csum_r, sa_r, da_r);
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
                busy_s  = 1'b0;
                idx_s   = 5'd0;
            end
        endcase
    end

    // State and output registers; reset aborts any header in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            sum_r   <= 16'h0000;
            csum_r  <= 16'h0000;
            idx_r   <= 5'd0;
            sa_r    <= 32'h0000_0000;
            da_r    <= 32'h0000_0000;
            tl_r    <= 16'h0000;
            ident_r <= 16'h0000;
            dout_r  <= 8'h00;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            sum_r   <= sum_s;
            csum_r  <= csum_s;
            idx_r   <= idx_s;
            sa_r    <= sa_s;
            da_r    <= da_s;
            tl_r    <= tl_s;
            ident_r <= ident_s;
            dout_r  <= dout_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    assign dout  = dout_r;
    assign valid = valid_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign err   = err_r;

endmodule
